// File: rtl/branch_predictor_if.sv
// Bundle between the branch predictor, the fetch stage and the decode stage.
//
// Lookup (fetch side):
//   lookup_pc_if     PC being fetched
//   pred_taken_if    predicted taken
//   pred_pc_if       predicted next PC
// Resolution (decode side):
//   upd_valid_id     a resolved branch/jal/jalr is present this cycle
//   upd_jump_id      the instruction is an unconditional jump
//   upd_pc_id        PC of the resolved instruction
//   upd_taken_id     actual direction
//   upd_target_id    actual target
//   pred_taken_id    prediction carried with the instruction
//   pred_pc_id       predicted next PC carried with the instruction
//   mispredict_id    prediction was wrong; redirect fetch and flush IF/ID
//   redirect_pc_id   correct next PC
// Control / statistics:
//   flush_btb        invalidate every BTB entry
//   lookup_cnt       resolved control instructions seen (saturating)
//   mispredict_cnt   mispredicts seen (saturating)
//
// The master modport is the pipeline side; the slave modport is the predictor.
interface branch_predictor_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    logic [XLEN-1:0]  lookup_pc_if;
    logic             pred_taken_if;
    logic [XLEN-1:0]  pred_pc_if;

    logic             upd_valid_id;
    logic             upd_jump_id;
    logic [XLEN-1:0]  upd_pc_id;
    logic             upd_taken_id;
    logic [XLEN-1:0]  upd_target_id;
    logic             pred_taken_id;
    logic [XLEN-1:0]  pred_pc_id;
    logic             mispredict_id;
    logic [XLEN-1:0]  redirect_pc_id;

    logic             flush_btb;
    logic [CNT_W-1:0] lookup_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output lookup_pc_if,
        input  pred_taken_if,
        input  pred_pc_if,
        output upd_valid_id,
        output upd_jump_id,
        output upd_pc_id,
        output upd_taken_id,
        output upd_target_id,
        output pred_taken_id,
        output pred_pc_id,
        input  mispredict_id,
        input  redirect_pc_id,
        output flush_btb,
        input  lookup_cnt,
        input  mispredict_cnt
    );

    modport slave (
        input  lookup_pc_if,
        output pred_taken_if,
        output pred_pc_if,
        input  upd_valid_id,
        input  upd_jump_id,
        input  upd_pc_id,
        input  upd_taken_id,
        input  upd_target_id,
        input  pred_taken_id,
        input  pred_pc_id,
        output mispredict_id,
        output redirect_pc_id,
        input  flush_btb,
        output lookup_cnt,
        output mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
//
// Fetch looks up the current PC combinationally and receives a predicted
// direction and next PC. Decode reports every resolved branch/jal/jalr; the
// predictor trains its entry, flags a mispredict against the prediction that
// travelled with the instruction, and supplies the redirect PC. Two saturating
// counters track resolved control instructions and mispredicts.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bp   branch_predictor_if.slave (lookup, resolution, flush, statistics)
//
// Entry layout: valid, tag = pc[XLEN-1:IDX_W+2], target, ctr
// (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T). Index = pc[IDX_W+1:2].
module branch_predictor #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    branch_predictor_if.slave bp
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    logic [CNT_W-1:0]   lookup_cnt_q, lookup_cnt_d;
    logic [CNT_W-1:0]   mispredict_cnt_q, mispredict_cnt_d;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // ------------------------------------------------------------------
    // Lookup: reads stored state only, so a same-cycle update is not seen
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_taken;

    assign lk_idx   = bp.lookup_pc_if[IDX_W+1:2];
    assign lk_tag   = bp.lookup_pc_if[XLEN-1:IDX_W+2];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && ctr_q[lk_idx][1];

    assign bp.pred_taken_if = lk_taken;
    assign bp.pred_pc_if    = lk_taken ? target_q[lk_idx] : bp.lookup_pc_if + XLEN'(4);

    // ------------------------------------------------------------------
    // Resolution: mispredict detection and redirect
    // ------------------------------------------------------------------
    logic [XLEN-1:0] redirect_pc;
    logic            mispredict;

    // Comparing next-PCs (not just directions) also catches a jalr whose
    // target moved while the direction stayed taken.
    assign redirect_pc = bp.upd_taken_id ? bp.upd_target_id : bp.upd_pc_id + XLEN'(4);
    assign mispredict  = bp.upd_valid_id && (redirect_pc != bp.pred_pc_id);

    assign bp.redirect_pc_id = redirect_pc;
    assign bp.mispredict_id  = mispredict;

    // The carried direction is implied by pred_pc_id, so it is not needed here.
    logic unused_pred_taken;
    assign unused_pred_taken = bp.pred_taken_id;

    // ------------------------------------------------------------------
    // Training
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    assign up_idx = bp.upd_pc_id[IDX_W+1:2];
    assign up_tag = bp.upd_pc_id[XLEN-1:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;

        if (bp.upd_valid_id) begin
            if (up_hit) begin
                if (bp.upd_jump_id) begin
                    ctr_d[up_idx]    = 2'b11;
                    target_d[up_idx] = bp.upd_target_id;
                end else if (bp.upd_taken_id) begin
                    ctr_d[up_idx]    = ctr_inc(ctr_q[up_idx]);
                    target_d[up_idx] = bp.upd_target_id;
                end else begin
                    ctr_d[up_idx]    = ctr_dec(ctr_q[up_idx]);
                end
            end else if (bp.upd_taken_id) begin
                // Miss-and-taken allocates over whatever lives in the slot.
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bp.upd_target_id;
                ctr_d[up_idx]    = bp.upd_jump_id ? 2'b11 : 2'b10;
            end
        end

        // Flush overrides any allocation made in the same cycle.
        if (bp.flush_btb) begin
            valid_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters (unaffected by flush)
    // ------------------------------------------------------------------
    always_comb begin
        lookup_cnt_d     = lookup_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (bp.upd_valid_id && !(&lookup_cnt_q)) begin
            lookup_cnt_d = lookup_cnt_q + CNT_W'(1);
        end
        if (mispredict && !(&mispredict_cnt_q)) begin
            mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
        end
    end

    assign bp.lookup_cnt     = lookup_cnt_q;
    assign bp.mispredict_cnt = mispredict_cnt_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            lookup_cnt_q     <= lookup_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: main instance with default sizing and a
// second instance with 2-bit counters for the saturation check.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst;

    always #10 clk = ~clk;

    branch_predictor_if #(.XLEN(32), .CNT_W(32)) bp ();
    branch_predictor_if #(.XLEN(32), .CNT_W(2))  bs ();

    branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp)
    );

    branch_predictor #(.XLEN(32), .ENTRIES(2), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bp  (bs)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_lk   = 0;
    logic [31:0] exp_mp   = 0;
    logic        last_mp  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_t,
                          input logic [31:0] exp_pc);
        bp.lookup_pc_if = pc;
        #1;
        check({tag, " taken"}, 64'(bp.pred_taken_if), 64'(exp_t));
        check({tag, " pc"}, 64'(bp.pred_pc_if), 64'(exp_pc));
    endtask

    // Present a resolution and check the combinational mispredict/redirect.
    task automatic upd_drive(input string tag, input logic [31:0] pc, input logic jump,
                             input logic taken, input logic [31:0] target,
                             input logic [31:0] ppc, input logic flush,
                             input logic exp_m, input logic [31:0] exp_rd);
        bp.upd_valid_id  = 1'b1;
        bp.upd_jump_id   = jump;
        bp.upd_pc_id     = pc;
        bp.upd_taken_id  = taken;
        bp.upd_target_id = target;
        bp.pred_pc_id    = ppc;
        bp.pred_taken_id = (ppc != pc + 32'd4);
        bp.flush_btb     = flush;
        #1;
        check({tag, " mispredict"}, 64'(bp.mispredict_id), 64'(exp_m));
        check({tag, " redirect"}, 64'(bp.redirect_pc_id), 64'(exp_rd));
        last_mp = exp_m;
    endtask

    // Clock the resolution in, retire it and check the counters.
    task automatic upd_commit(input string tag);
        tick();
        bp.upd_valid_id = 1'b0;
        bp.flush_btb    = 1'b0;
        exp_lk++;
        if (last_mp) exp_mp++;
        #1;
        check({tag, " mispredict gated"}, 64'(bp.mispredict_id), 64'd0);
        check({tag, " lookup_cnt"}, 64'(bp.lookup_cnt), 64'(exp_lk));
        check({tag, " mispredict_cnt"}, 64'(bp.mispredict_cnt), 64'(exp_mp));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bp.lookup_pc_if  = 32'h100;
        bp.upd_valid_id  = 1'b0;
        bp.upd_jump_id   = 1'b0;
        bp.upd_pc_id     = '0;
        bp.upd_taken_id  = 1'b0;
        bp.upd_target_id = '0;
        bp.pred_taken_id = 1'b0;
        bp.pred_pc_id    = '0;
        bp.flush_btb     = 1'b0;
        bs.lookup_pc_if  = '0;
        bs.upd_valid_id  = 1'b0;
        bs.upd_jump_id   = 1'b0;
        bs.upd_pc_id     = 32'h10;
        bs.upd_taken_id  = 1'b1;
        bs.upd_target_id = 32'h40;
        bs.pred_taken_id = 1'b0;
        bs.pred_pc_id    = 32'h14;
        bs.flush_btb     = 1'b0;

        // Reset state
        lookup("reset 0x100", 32'h100, 1'b0, 32'h104);
        check("reset lookup_cnt", 64'(bp.lookup_cnt), 64'd0);
        check("reset mispredict_cnt", 64'(bp.mispredict_cnt), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // First taken branch allocates (ctr 10); same-cycle lookup sees old data
        upd_drive("br0 T", 32'h100, 1'b0, 1'b1, 32'h80, 32'h104, 1'b0, 1'b1, 32'h80);
        lookup("same-cycle 0x100", 32'h100, 1'b0, 32'h104);
        upd_commit("br0 T");
        lookup("after alloc", 32'h100, 1'b1, 32'h80);

        // 10 -> 01 -> 00 -> 00
        upd_drive("br0 NT1", 32'h100, 1'b0, 1'b0, 32'h80, 32'h80, 1'b0, 1'b1, 32'h104);
        upd_commit("br0 NT1");
        lookup("ctr 01", 32'h100, 1'b0, 32'h104);
        upd_drive("br0 NT2", 32'h100, 1'b0, 1'b0, 32'h80, 32'h104, 1'b0, 1'b0, 32'h104);
        upd_commit("br0 NT2");
        lookup("ctr 00", 32'h100, 1'b0, 32'h104);
        upd_drive("br0 NT3", 32'h100, 1'b0, 1'b0, 32'h80, 32'h104, 1'b0, 1'b0, 32'h104);
        upd_commit("br0 NT3");

        // 00 -> 01 (still NT) -> 10 (taken)
        upd_drive("br0 T1", 32'h100, 1'b0, 1'b1, 32'h80, 32'h104, 1'b0, 1'b1, 32'h80);
        upd_commit("br0 T1");
        lookup("ctr 01 again", 32'h100, 1'b0, 32'h104);
        upd_drive("br0 T2", 32'h100, 1'b0, 1'b1, 32'h80, 32'h104, 1'b0, 1'b1, 32'h80);
        upd_commit("br0 T2");
        lookup("ctr 10 again", 32'h100, 1'b1, 32'h80);

        // Aliasing: 0x140 shares index 0 with 0x100
        upd_drive("alias T", 32'h140, 1'b0, 1'b1, 32'h500, 32'h144, 1'b0, 1'b1, 32'h500);
        upd_commit("alias T");
        lookup("alias 0x100 miss", 32'h100, 1'b0, 32'h104);
        lookup("alias 0x140 hit", 32'h140, 1'b1, 32'h500);
        upd_drive("alias NT", 32'h100, 1'b0, 1'b0, 32'h80, 32'h104, 1'b0, 1'b0, 32'h104);
        upd_commit("alias NT");
        lookup("no realloc 0x100", 32'h100, 1'b0, 32'h104);
        lookup("no realloc 0x140", 32'h140, 1'b1, 32'h500);

        // jal allocates strong-taken: one NT only drops it to weak-taken
        upd_drive("jal", 32'h200, 1'b1, 1'b1, 32'h300, 32'h204, 1'b0, 1'b1, 32'h300);
        upd_commit("jal");
        lookup("jal alloc", 32'h200, 1'b1, 32'h300);
        upd_drive("jal NT", 32'h200, 1'b0, 1'b0, 32'h300, 32'h300, 1'b0, 1'b1, 32'h204);
        upd_commit("jal NT");
        lookup("ctr 11->10", 32'h200, 1'b1, 32'h300);

        // jalr with a moved target
        upd_drive("jalr", 32'h200, 1'b1, 1'b1, 32'h400, 32'h300, 1'b0, 1'b1, 32'h400);
        lookup("jalr same-cycle", 32'h200, 1'b1, 32'h300);
        upd_commit("jalr");
        lookup("jalr target", 32'h200, 1'b1, 32'h400);
        upd_drive("jalr NT1", 32'h200, 1'b0, 1'b0, 32'h400, 32'h400, 1'b0, 1'b1, 32'h204);
        upd_commit("jalr NT1");
        lookup("jalr ctr 10", 32'h200, 1'b1, 32'h400);
        upd_drive("jalr NT2", 32'h200, 1'b0, 1'b0, 32'h400, 32'h400, 1'b0, 1'b1, 32'h204);
        upd_commit("jalr NT2");
        lookup("jalr ctr 01", 32'h200, 1'b0, 32'h204);

        // Flush beats a simultaneous allocation; counters still move
        upd_drive("flush", 32'h300, 1'b0, 1'b1, 32'h600, 32'h304, 1'b1, 1'b1, 32'h600);
        upd_commit("flush");
        lookup("flush 0x300", 32'h300, 1'b0, 32'h304);
        lookup("flush 0x140", 32'h140, 1'b0, 32'h144);

        // Reallocate, then reset asynchronously in the middle of an update
        upd_drive("realloc", 32'h100, 1'b0, 1'b1, 32'h80, 32'h104, 1'b0, 1'b1, 32'h80);
        upd_commit("realloc");
        lookup("realloc 0x100", 32'h100, 1'b1, 32'h80);
        upd_drive("pre-rst", 32'h140, 1'b0, 1'b1, 32'h700, 32'h144, 1'b0, 1'b1, 32'h700);
        #1;
        rst = 1'b1;
        #1;
        check("async rst lookup_cnt", 64'(bp.lookup_cnt), 64'd0);
        check("async rst mispredict_cnt", 64'(bp.mispredict_cnt), 64'd0);
        check("async rst mispredict_id", 64'(bp.mispredict_id), 64'd1);
        lookup("async rst 0x100", 32'h100, 1'b0, 32'h104);
        tick();
        lookup("rst held 0x140", 32'h140, 1'b0, 32'h144);
        bp.upd_valid_id = 1'b0;
        rst = 1'b0;
        exp_lk = 0;
        exp_mp = 0;
        tick();
        check("post rst lookup_cnt", 64'(bp.lookup_cnt), 64'd0);
        check("post rst mispredict_cnt", 64'(bp.mispredict_cnt), 64'd0);
        lookup("post rst 0x140", 32'h140, 1'b0, 32'h144);

        // Saturation on the 2-bit counter instance: every update mispredicts
        bs.upd_valid_id = 1'b1;
        #1;
        check("sat mispredict_id", 64'(bs.mispredict_id), 64'd1);
        tick();
        check("sat mispredict_cnt 1", 64'(bs.mispredict_cnt), 64'd1);
        tick();
        tick();
        check("sat mispredict_cnt 3", 64'(bs.mispredict_cnt), 64'd3);
        tick();
        check("sat mispredict_cnt held", 64'(bs.mispredict_cnt), 64'd3);
        check("sat lookup_cnt held", 64'(bs.lookup_cnt), 64'd3);
        bs.upd_valid_id = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. It supplies next-PC predictions to IF and takes branch/jump resolutions from ID, where rs1/rs2 compare and target computation already happen. It replaces the ID-resolve-only static not-taken scheme with dynamic prediction. It also detects mispredicts, produces the redirect PC, and keeps saturating performance counters.

## Interface
Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES).
- CNT_W, 32, width of performance counters.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- lookup_pc_if  input  XLEN  PC being fetched.
- pred_taken_if  output  1  prediction: taken.
- pred_pc_if  output  XLEN  predicted next PC.
- upd_valid_id  input  1  ID holds a resolved branch/jal/jalr this cycle.
- upd_jump_id  input  1  instruction is jal/jalr (unconditional).
- upd_pc_id  input  XLEN  PC of resolved instruction.
- upd_taken_id  input  1  actual direction.
- upd_target_id  input  XLEN  actual target (valid when taken).
- pred_taken_id  input  1  prediction carried down the pipe with the instruction.
- pred_pc_id  input  XLEN  predicted next PC carried with the instruction.
- mispredict_id  output  1  prediction wrong; IF must be redirected and IF/ID flushed.
- redirect_pc_id  output  XLEN  correct next PC.
- flush_btb  input  1  invalidate all entries (e.g. fence.i).
- lookup_cnt  output  CNT_W  count of resolved control instructions.
- mispredict_cnt  output  CNT_W  count of mispredicts.

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[XLEN-1:IDX_W+2]. Bits [1:0] are ignored.
- Entry contents: valid, tag, target (XLEN), ctr (2 bits: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
- Lookup (combinational from stored state):
  - hit = valid & tag match.
  - pred_taken_if = hit & ctr[1].
  - pred_pc_if = pred_taken_if ? target : lookup_pc_if+4 (mod 2^XLEN).
- Update when upd_valid_id=1:
  - Hit with upd_jump_id=1: ctr←11, target←upd_target_id.
  - Hit with a conditional branch: taken → ctr saturating +1 and target←upd_target_id; not taken → ctr saturating −1, target unchanged.
  - Miss and taken: allocate (overwrite the slot). valid←1, tag, target←upd_target_id, ctr←11 for a jump or 10 for a branch.
  - Miss and not taken: no change.
- Mispredict (combinational, gated by upd_valid_id):
  - redirect_pc_id = upd_taken_id ? upd_target_id : upd_pc_id+4.
  - mispredict_id = upd_valid_id & (redirect_pc_id != pred_pc_id).
  - A jalr hit whose target has changed therefore flags a mispredict.
- Performance counters:
  - lookup_cnt += 1 on every upd_valid_id.
  - mispredict_cnt += 1 on every mispredict_id.
  - Both saturate at all-ones; no wrap.
- flush_btb=1: all valid←0 at the next edge; ctr and target are don't-care. Performance counters are unaffected.

## Timing
- Lookup and mispredict/redirect: 0-cycle latency (combinational).
- Update: visible to lookup the cycle after the edge on which upd_valid_id is sampled.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. No internal bypass.
- flush_btb together with upd_valid_id: flush wins and the entry stays invalid. Counters still update.
- Reset (asynchronous, any cycle, including mid-update):
  - All valid←0, all ctr←01.
  - lookup_cnt = mispredict_cnt = 0.
  - Consequently pred_taken_if=0 and pred_pc_if=lookup_pc_if+4 during and after reset.
  - mispredict_id depends only on its inputs.
- No stall input. The caller deasserts upd_valid_id for stalled or flushed ID slots.

## Test plan
- Reset, then lookup 0x100 → pred_taken_if=0, pred_pc_if=0x104. Counters 0.
- Resolve a branch at PC 0x100 (taken to 0x80) with pred_pc_id=0x104 → mispredict_id=1, redirect 0x80, mispredict_cnt=1. Next cycle lookup 0x100 → taken, 0x80 (ctr=10).
- Same branch not taken twice → ctr 10→01→00. Lookup predicts 0x104. A third not-taken keeps ctr=00. Then two taken → prediction flips back to taken only after the second.
- Aliasing with ENTRIES=16: a taken branch at 0x140 (same index as 0x100, different tag) replaces the entry → lookup 0x100 misses → 0x104. The not-taken branch at 0x100 does not reallocate.
- jal at 0x200 to 0x300 allocates with ctr=11. A jalr at the same PC resolving to 0x400 with pred_pc_id=0x300 → mispredict_id=1, redirect 0x400, target updated.
- Same-cycle update and lookup at 0x100 returns old data. flush_btb with a simultaneous update → entry invalid. Assert rst mid-run → counters and predictions return to reset values immediately.
- Force mispredict_cnt to all-ones → a further mispredict keeps it all-ones.
